// File: rtl/regs.sv
// regs: 32 x 64-bit general-purpose register file for the multi-cycle PPC core.
// Two registered read ports (Decode) and two write ports (Writeback).
// Bus bit 0 is the MSB throughout ([0:4] indices, [0:63] data).
// Optional build macro REGS_BYPASS_EN: a read that lands on the same edge as a
// write to the same index captures the written data (write-through). Without
// it, the read returns the old contents (read-before-write).
module regs #(
  parameter int NREGS = 32,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ren0,
  input  logic [0:4]       raddr0,
  output logic [0:WIDTH-1] rdata0,
  input  logic             ren1,
  input  logic [0:4]       raddr1,
  output logic [0:WIDTH-1] rdata1,
  input  logic             wen0,
  input  logic [0:4]       waddr0,
  input  logic [0:WIDTH-1] wdata0,
  input  logic             wen1,
  input  logic [0:4]       waddr1,
  input  logic [0:WIDTH-1] wdata1
);

  // Register storage; index range matches the 5-bit address buses.
  logic [NREGS-1:0][0:WIDTH-1] mem;

  // Next value each read port will capture.
  logic [0:WIDTH-1] rdNext0;
  logic [0:WIDTH-1] rdNext1;

`ifdef REGS_BYPASS_EN
  // Write-through forwarding: port 1 has priority, mirroring the array's
  // conflict rule so a forwarded value always equals what gets stored.
  always_comb begin
    rdNext0 = mem[raddr0];
    if (wen0 && (waddr0 == raddr0)) rdNext0 = wdata0;
    if (wen1 && (waddr1 == raddr0)) rdNext0 = wdata1;
    rdNext1 = mem[raddr1];
    if (wen0 && (waddr0 == raddr1)) rdNext1 = wdata0;
    if (wen1 && (waddr1 == raddr1)) rdNext1 = wdata1;
  end
`else
  // Read-before-write: capture the pre-edge contents.
  always_comb begin
    rdNext0 = mem[raddr0];
    rdNext1 = mem[raddr1];
  end
`endif

  // Write ports; port 1 is applied last so it wins a same-index conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      if (wen0) mem[waddr0] <= wdata0;
      if (wen1) mem[waddr1] <= wdata1;
    end
  end

  // Read ports: capture on enable, otherwise hold indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (ren0) rdata0 <= rdNext0;
      if (ren1) rdata1 <= rdNext1;
    end
  end

endmodule

// File: tb/tb_regs.sv
// tb_regs: directed, table-driven bench for the regs register file.
// Expected values for same-edge read/write depend on REGS_BYPASS_EN.
module tb_regs;

`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ren0, ren1, wen0, wen1;
  logic [0:4]  raddr0, raddr1, waddr0, waddr1;
  logic [0:63] wdata0, wdata1, rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  regs dut (
    .clk(clk), .rst_n(rst_n),
    .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren0;
    logic [0:4]  ra0;
    logic        ren1;
    logic [0:4]  ra1;
    logic        wen0;
    logic [0:4]  wa0;
    logic [0:63] wd0;
    logic        wen1;
    logic [0:4]  wa1;
    logic [0:63] wd1;
    logic [0:63] e0;
    logic [0:63] e1;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r0, logic [0:4] a0, logic r1, logic [0:4] a1,
                              logic w0, logic [0:4] wa0, logic [0:63] wd0,
                              logic w1, logic [0:4] wa1, logic [0:63] wd1,
                              logic [0:63] e0, logic [0:63] e1);
    vec_t v;
    v.ren0 = r0; v.ra0 = a0; v.ren1 = r1; v.ra1 = a1;
    v.wen0 = w0; v.wa0 = wa0; v.wd0 = wd0;
    v.wen1 = w1; v.wa1 = wa1; v.wd1 = wd1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [0:63] act, input logic [0:63] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    ren0 = 0; ren1 = 0; wen0 = 0; wen1 = 0;
    raddr0 = '0; raddr1 = '0; waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  localparam logic [0:63] K = 64'h0123456789ABCDEF;

  initial begin
    idle();
    rst_n = 1'b1;

    // rows: ren0 ra0 ren1 ra1 | wen0 wa0 wd0 | wen1 wa1 wd1 | exp rdata0 exp rdata1
    vecs[0]  = mk(1,5, 1,31, 0,0,0,       0,0,0,        0, 0);
    vecs[1]  = mk(0,0, 0,0,  1,3,K,       0,0,0,        0, 0);
    vecs[2]  = mk(0,0, 1,3,  0,0,0,       0,0,0,        0, K);
    vecs[3]  = mk(1,3, 0,0,  0,0,0,       0,0,0,        K, K);
    vecs[4]  = mk(0,0, 0,0,  1,3,64'hFFFF,0,0,0,        K, K);
    vecs[5]  = mk(0,0, 0,0,  0,0,0,       0,0,0,        K, K);
    vecs[6]  = mk(1,3, 0,0,  0,0,0,       0,0,0,        64'hFFFF, K);
    vecs[7]  = mk(0,0, 0,0,  1,7,64'h11,  1,8,64'h22,   64'hFFFF, K);
    vecs[8]  = mk(1,7, 1,8,  0,0,0,       0,0,0,        64'h11, 64'h22);
    vecs[9]  = mk(0,0, 0,0,  1,9,64'hAA,  1,9,64'hBB,   64'h11, 64'h22);
    vecs[10] = mk(1,9, 1,9,  0,0,0,       0,0,0,        64'hBB, 64'hBB);
    vecs[11] = mk(0,0, 0,0,  1,4,64'h5,   0,0,0,        64'hBB, 64'hBB);
    vecs[12] = mk(1,4, 1,4,  1,4,64'h6,   0,0,0,
                  BYP ? 64'h6 : 64'h5, BYP ? 64'h6 : 64'h5);
    vecs[13] = mk(1,4, 1,0,  0,0,0,       0,0,0,        64'h6, 0);
    vecs[14] = mk(1,0, 0,0,  0,0,0,       1,0,64'hDEAD, BYP ? 64'hDEAD : 64'h0, 0);
    vecs[15] = mk(0,0, 1,0,  0,0,0,       0,0,0,        BYP ? 64'hDEAD : 64'h0, 64'hDEAD);
    vecs[16] = mk(1,10,0,0,  1,10,64'h1,  1,10,64'h2,   BYP ? 64'h2 : 64'h0, 64'hDEAD);
    vecs[17] = mk(1,10,0,0,  0,0,0,       0,0,0,        64'h2, 64'hDEAD);

    // Reset asserted before any clock edge: outputs must be 0.
    #2 rst_n = 1'b0;
    #1;
    check("reset_rdata0", rdata0, 64'h0);
    check("reset_rdata1", rdata1, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive on negedge, compare 1 time unit after the next posedge.
    for (int i = 0; i < NV; i++) begin
      ren0 = vecs[i].ren0; raddr0 = vecs[i].ra0;
      ren1 = vecs[i].ren1; raddr1 = vecs[i].ra1;
      wen0 = vecs[i].wen0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
      wen1 = vecs[i].wen1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].e0);
      check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e1);
      @(negedge clk);
      idle();
    end

    // Async reset mid-run, between edges, with no clock edge needed.
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rdata0", rdata0, 64'h0);
    check("midreset_rdata1", rdata1, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every register reads back 0 after the mid-run reset.
    for (int r = 0; r < 32; r++) begin
      ren0 = 1; raddr0 = 5'(r);
      ren1 = 1; raddr1 = 5'(31 - r);
      @(posedge clk);
      #1;
      check($sformatf("postreset_r%0d_p0", r), rdata0, 64'h0);
      check($sformatf("postreset_r%0d_p1", 31 - r), rdata1, 64'h0);
      @(negedge clk);
    end
    idle();

    // After reset the array is writable again: write r3, read it back.
    wen0 = 1; waddr0 = 3; wdata0 = K;
    @(negedge clk);
    idle();
    ren1 = 1; raddr1 = 3;
    @(posedge clk);
    #1;
    check("postreset_write_r3", rdata1, K);
    @(negedge clk);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
